irq_arbiter: RTL

IRQ_ARBITER -- requirements
Module: irq_arbiter

---
 rtl/irq_arbiter_if.sv | 32 +++
 rtl/irq_arbiter.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/irq_arbiter_if.sv
// ---------------------------------------------------------------------------
// irq_arbiter_if : request, register and core handshake bundle for irq_arbiter
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface irq_arbiter_if #(
  parameter int NUM_SRC = 8
);
  logic [NUM_SRC-1:0] src_i;
  logic               we_i;
  logic [7:0]         addr_i;
  logic [31:0]        wdata_i;
  logic [31:0]        rdata_o;
  logic               irq_o;
  logic [7:0]         irq_id_o;
  logic               claim_i;
  logic               complete_i;
  logic               busy_o;

  modport master (
    output src_i, we_i, addr_i, wdata_i, claim_i, complete_i,
    input  rdata_o, irq_o, irq_id_o, busy_o
  );

  modport slave (
    input  src_i, we_i, addr_i, wdata_i, claim_i, complete_i,
    output rdata_o, irq_o, irq_id_o, busy_o
  );
endinterface

`default_nettype wire

// File: rtl/irq_arbiter.sv
// ---------------------------------------------------------------------------
// irq_arbiter : synchronised edge-triggered interrupt sources, round-robin
//               selection and a claim/complete handshake to one core
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module irq_arbiter #(
  parameter int NUM_SRC     = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  irq_arbiter_if.slave  bus
);

  localparam int         IDW       = 5;
  localparam logic [2:0] S_IDLE    = 3'b001;
  localparam logic [2:0] S_ASSERT  = 3'b010;
  localparam logic [2:0] S_SERVICE = 3'b100;
  localparam logic [7:0] A_PEND    = 8'h00;
  localparam logic [7:0] A_EN      = 8'h04;
  localparam logic [7:0] A_CLR     = 8'h08;
  localparam logic [7:0] A_STAT    = 8'h0C;

  logic [NUM_SRC-1:0] r_sync [SYNC_STAGES];
  logic [NUM_SRC-1:0] r_prev;
  logic [SYNC_STAGES:0] r_armed;
  logic [NUM_SRC-1:0] r_pending;
  logic [NUM_SRC-1:0] r_enable;
  logic [2:0]         r_state;
  logic [IDW-1:0]     r_rr_ptr;
  logic [IDW-1:0]     r_winner;

  logic [NUM_SRC-1:0] w_edge;
  logic [NUM_SRC-1:0] w_req;
  logic [NUM_SRC-1:0] w_clr;
  logic [NUM_SRC-1:0] w_winner_oh;
  logic [NUM_SRC-1:0] w_pending_nxt;
  logic [NUM_SRC-1:0] w_enable_nxt;
  logic [2:0]         w_state_nxt;
  logic [IDW-1:0]     w_rr_winner;
  logic [IDW-1:0]     w_hi;
  logic [IDW-1:0]     w_lo;
  logic               w_hi_found;
  logic               w_found;
  logic               w_claim;
  logic               w_wr_en;
  logic               w_wr_clr;
  logic               w_unused;

  // Edges are masked until the synchroniser has been refilled after reset, so a
  // line already high at release is not mistaken for a new request.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int s = 0; s < SYNC_STAGES; s++) r_sync[s] <= '0;
      r_prev  <= '0;
      r_armed <= '0;
    end else begin
      r_sync[0] <= bus.src_i;
      for (int s = 1; s < SYNC_STAGES; s++) r_sync[s] <= r_sync[s-1];
      r_prev  <= r_sync[SYNC_STAGES-1];
      r_armed <= {r_armed[SYNC_STAGES-1:0], 1'b1};
    end
  end

  assign w_edge = r_armed[SYNC_STAGES] ? (r_sync[SYNC_STAGES-1] & ~r_prev) : '0;

  assign w_wr_en       = bus.we_i && (bus.addr_i == A_EN);
  assign w_wr_clr      = bus.we_i && (bus.addr_i == A_CLR);
  assign w_claim       = bus.claim_i && (r_state == S_ASSERT);
  assign w_winner_oh   = {{(NUM_SRC-1){1'b0}}, 1'b1} << r_winner;
  assign w_clr         = (w_claim ? w_winner_oh : '0) |
                         (w_wr_clr ? bus.wdata_i[NUM_SRC-1:0] : '0);
  assign w_pending_nxt = (r_pending & ~w_clr) | w_edge;
  assign w_enable_nxt  = w_wr_en ? bus.wdata_i[NUM_SRC-1:0] : r_enable;
  assign w_req         = r_pending & r_enable;
  assign w_unused      = ^bus.wdata_i[31:NUM_SRC];

  // Descending scan keeps the lowest requester above rr_ptr (w_hi) and the
  // lowest overall (w_lo); the latter is the wrap-around choice.
  always_comb begin
    w_hi       = '0;
    w_lo       = '0;
    w_hi_found = 1'b0;
    w_found    = |w_req;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (w_req[i]) begin
        w_lo = IDW'(i);
        if (i > int'(r_rr_ptr)) begin
          w_hi       = IDW'(i);
          w_hi_found = 1'b1;
        end
      end
    end
    w_rr_winner = w_hi_found ? w_hi : w_lo;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (w_found) w_state_nxt = S_ASSERT;
      S_ASSERT: begin
        if (w_claim)
          w_state_nxt = S_SERVICE;
        else if ((w_pending_nxt & w_enable_nxt & w_winner_oh) == '0)
          w_state_nxt = S_IDLE;
      end
      S_SERVICE: if (bus.complete_i) w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state   <= S_IDLE;
      r_pending <= '0;
      r_enable  <= '0;
      r_winner  <= '0;
      r_rr_ptr  <= IDW'(NUM_SRC - 1);
    end else begin
      r_state   <= w_state_nxt;
      r_pending <= w_pending_nxt;
      r_enable  <= w_enable_nxt;
      if (r_state == S_IDLE && w_found) r_winner <= w_rr_winner;
      if (w_claim)                      r_rr_ptr <= r_winner;
    end
  end

  assign bus.irq_o    = (r_state == S_ASSERT);
  assign bus.busy_o   = (r_state == S_SERVICE);
  assign bus.irq_id_o = (r_state == S_ASSERT || r_state == S_SERVICE) ?
                        8'(r_winner) + 8'd1 : 8'd0;

  always_comb begin
    bus.rdata_o = '0;
    case (bus.addr_i)
      A_PEND: bus.rdata_o = {{(32-NUM_SRC){1'b0}}, r_pending};
      A_EN:   bus.rdata_o = {{(32-NUM_SRC){1'b0}}, r_enable};
      A_STAT: bus.rdata_o = {23'b0, bus.busy_o, bus.irq_id_o};
      default: bus.rdata_o = '0;
    endcase
  end

endmodule

`default_nettype wire
